// File: rtl/shifter_pkg.sv
// Shared definitions for the multifunction barrel-shifter stages.
package shifter_pkg;
  localparam int WIDTH = 8;
  typedef logic [WIDTH-1:0] word_t;
endpackage

// File: rtl/bit_reverse.sv
// Combinational mirror of a word: bit i of the result is bit WIDTH-1-i of a.
module bit_reverse
  import shifter_pkg::*;
#(
  parameter int WIDTH = shifter_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_mirror
    assign y[i] = a[WIDTH-1-i];
  end

endmodule

// File: rtl/reverse_bit_reg.sv
// Registered bit-order reverser stage: y is a mirrored (en=1) or passed-through
// (en=0) copy of a, one clock after sampling.
module reverse_bit_reg
  import shifter_pkg::*;
#(
  parameter int WIDTH = shifter_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic             en,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] mirrored;

  bit_reverse #(.WIDTH(WIDTH)) u_bit_reverse (
    .a (a),
    .y (mirrored)
  );

  // Output register: the only state in the stage, so it clears with reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y <= '0;
    end else begin
      y <= en ? mirrored : a;
    end
  end

endmodule

// File: tb/tb_reverse_bit_reg.sv
// Bench for reverse_bit_reg at WIDTH = 8, 5 and 16.
module tb_reverse_bit_reg;

  logic        clk;
  logic        rst_n;
  logic [7:0]  a8,  y8;
  logic [4:0]  a5,  y5;
  logic [15:0] a16, y16;
  logic        en8, en5, en16;

  int checks = 0;
  int errors = 0;

  reverse_bit_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .en(en8), .y(y8)
  );
  reverse_bit_reg #(.WIDTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .a(a5), .en(en5), .y(y5)
  );
  reverse_bit_reg #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .a(a16), .en(en16), .y(y16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: build the mirrored word arithmetically, LSB of v becomes MSB.
  function automatic logic [31:0] rev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = 0;
    for (int i = 0; i < w; i++) r = r * 2 + ((v >> i) & 1);
    return r;
  endfunction

  function automatic logic [31:0] model(input logic [31:0] v, input logic e, input int w);
    return e ? rev(v, w) : v;
  endfunction

  task automatic step8(input string tag, input logic [7:0] av, input logic ev,
                       input logic [7:0] exp);
    @(negedge clk);
    a8  = av;
    en8 = ev;
    @(posedge clk);
    #1;
    chk(tag, {24'h0, y8}, {24'h0, exp});
  endtask

  initial begin
    logic [31:0] r8, r5, r16;
    logic        e8, e5, e16;

    rst_n = 1'b0;
    a8 = 8'h93; en8 = 1'b1;
    a5 = '0; en5 = 1'b0;
    a16 = '0; en16 = 1'b0;

    // 1: reset held with clock running, then release
    #1;
    chk("reset_t0", {24'h0, y8}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("reset_hold", {24'h0, y8}, 32'h0);
    end
    chk("reset_y5", {27'h0, y5}, 32'h0);
    chk("reset_y16", {16'h0, y16}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_edge", {24'h0, y8}, 32'hC9);

    // 2: pass-through
    step8("pass_93", 8'h93, 1'b0, 8'h93);
    step8("pass_e5", 8'hE5, 1'b0, 8'hE5);
    step8("pass_3e", 8'h3E, 1'b0, 8'h3E);

    // 3: reversed
    step8("rev_93", 8'h93, 1'b1, 8'hC9);
    step8("rev_e5", 8'hE5, 1'b1, 8'hA7);
    step8("rev_3e", 8'h3E, 1'b1, 8'h7C);

    // 4: en toggling, then palindromes
    for (int i = 0; i < 6; i++)
      step8("tog_01", 8'h01, i[0], i[0] ? 8'h80 : 8'h01);
    for (int i = 0; i < 4; i++)
      step8("tog_81", 8'h81, i[0], 8'h81);
    step8("pal_00", 8'h00, 1'b1, 8'h00);
    step8("pal_ff", 8'hFF, 1'b1, 8'hFF);
    step8("pal_3c", 8'h3C, 1'b1, 8'h3C);

    // 5: asynchronous reset mid-stream
    step8("stream_e5", 8'hE5, 1'b1, 8'hA7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_clear", {24'h0, y8}, 32'h0);
    @(negedge clk);
    a8 = 8'h3E;
    en8 = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset", {24'h0, y8}, 32'h7C);

    // 6: random stimulus on all three widths
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      a8  = 8'($urandom);
      a5  = 5'($urandom);
      a16 = 16'($urandom);
      en8  = 1'($urandom);
      en5  = 1'($urandom);
      en16 = 1'($urandom);
      r8  = model({24'h0, a8}, en8, 8);
      r5  = model({27'h0, a5}, en5, 5);
      r16 = model({16'h0, a16}, en16, 16);
      e8 = en8;
      e5 = en5;
      e16 = en16;
      @(posedge clk);
      #1;
      chk("rnd_w8", {24'h0, y8}, r8);
      chk("rnd_w5", {27'h0, y5}, r5);
      chk("rnd_w16", {16'h0, y16}, r16);
      if (e8) chk("twice_w8", rev({24'h0, y8}, 8), {24'h0, a8});
      if (e5) chk("twice_w5", rev({27'h0, y5}, 5), {27'h0, a5});
      if (e16) chk("twice_w16", rev({16'h0, y16}, 16), {16'h0, a16});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reverse_bit_reg.md
Name: reverse_bit_reg

Overview:
Registered bit-order reverser used as the "reverse" function stage of the multifunction barrel shifter. When enabled, the input word is mirrored (MSB<->LSB); otherwise it passes through unchanged. The result is registered once, so the stage drops into the clocked shifter datapath with a fixed one-cycle latency.

Parameters:
WIDTH, 8, data word width in bits (legal: WIDTH >= 2).

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst_n  input  1  asynchronous active-low reset.
a  input  WIDTH  data word to transform.
en  input  1  1 = output the bit-reversed a; 0 = output a unchanged.
y  output  WIDTH  registered result.

Behaviour:
- Reset: asynchronous and active-low. While rst_n=0, y=0 immediately, independent of clk. Deassertion is synchronised externally; the first capture occurs on the first rising clk edge with rst_n=1.
- Function: y_next[i] = en ? a[WIDTH-1-i] : a[i], for i = 0..WIDTH-1.
- Latency: exactly 1 cycle. a and en are sampled together on the same rising edge, and y reflects them after that edge. There is no handshake or stall; the block captures new data on every cycle.
- en is a plain per-cycle data-path select. Toggling en takes effect on the next edge with no pipeline flush or bubble.
- Boundary cases:
  - Palindromic words (0x00, 0xFF, 0x81, 0x3C for WIDTH=8) give the same y for either en value.
  - Odd WIDTH: the middle bit maps to itself.
- Reset mid-stream: y clears to 0 at once. The first post-reset edge loads the then-current a/en, with no stale data.
- X handling: there is no internal state other than y, and no X is generated internally.

Decomposition:
- Shared package (shifter_pkg): WIDTH default constant, and a data word typedef sized by it, reused by the other barrel-shifter stages.
- Sub-module: one combinational sub-module, bit_reverse (a -> mirrored a, WIDTH-parameterised generate loop). The top holds the en mux and the output register.

Test Plan:
1. Hold rst_n=0 with a=0x93, en=1 and clk running -> y=0x00 throughout. Release reset -> y=0xC9 after the first edge.
2. en=0; apply a=0x93, 0xE5, 0x3E on consecutive cycles -> y=0x93, 0xE5, 0x3E, each one cycle after its input.
3. en=1; apply a=0x93, 0xE5, 0x3E -> y=0xC9, 0xA7, 0x7C, each with one-cycle latency.
4. a=0x01 held constant; toggle en 0/1 every cycle -> y alternates 0x01, 0x80 lagging en by one cycle. Then a=0x81 with en toggling -> y constant 0x81.
5. Streaming en=1, a=0xE5; assert rst_n=0 between clock edges -> y drops to 0x00 before the next edge. Release with a=0x3E -> y=0x7C on the next edge.
6. Random a and en over 1000 cycles (also at WIDTH=5 and WIDTH=16) -> y equals the reference model of the previous cycle's inputs; applying reverse twice in a scoreboard returns the original a.
